// File: rtl/btn_digit_editor_pkg.sv
// Purpose: shared constants, FSM encoding and digit addressing for the push-button digit editor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: DIGITS/DIGIT_W, state_t (S_IDLE/S_WRITE), digit_lsb() mapping a digit index to its bit position in num.
package btn_digit_pkg;

   localparam int DIGITS  = 4;
   localparam int DIGIT_W = 4;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_t;

   // Digit 0 is the most significant nibble, so digit i lives at bit 12-4*i.
   function automatic logic [3:0] digit_lsb(input logic [1:0] idx);
      return 4'd12 - {idx, 2'b00};
   endfunction

endpackage

// File: rtl/btn_digit_editor_debounce.sv
// Purpose: 2-FF synchroniser, stable-level debounce counter and press (0->1) pulse for one push-button.
// Latency: a clean level change is accepted DEB_LIMIT+2 cycles after it reaches btn; rise pulses in that same cycle.
// Backpressure: none; rise is a single-cycle pulse that the consumer must capture.
// Ports: clk, rst_n (async active-low), btn (raw asynchronous), rise (one-cycle accepted-press pulse).
module btn_debounce #(
   parameter int unsigned DEB_LIMIT = 1_000_000,
   parameter int unsigned DEB_W     = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_LIMIT - 1);

   logic [1:0]       sync_ff;
   logic             sync;
   logic             stable;
   logic [DEB_W-1:0] cnt;

   assign sync = sync_ff[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= 2'b00;
         stable  <= 1'b0;
         cnt     <= '0;
         rise    <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[0], btn};
         rise    <= 1'b0;
         if (sync == stable) begin
            // Any bounce back to the accepted level restarts the qualification window.
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= sync;
            cnt    <= '0;
            // Only presses generate requests; releases just update the level.
            rise   <= sync;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_digit_editor.sv
// Purpose: debounced push-buttons increment individual hex digits of num through one shared round-robin incrementer.
// Latency: num changes 2 cycles after a press sets pending (grant cycle, then write cycle); one update per 2 cycles.
// Backpressure: none upstream; a press on an already-pending digit is merged, at most one request queued per digit.
// Ports: clk, rst_n (async active-low), btn[3:0] raw buttons, clr (sync clear to INIT_VAL),
//        num[15:0] value (btn[0] -> num[15:12]), upd_valid/upd_idx update strobe and digit, busy.
module btn_digit_editor
   import btn_digit_pkg::*;
#(
   parameter int unsigned DEB_LIMIT = 1_000_000,
   parameter int unsigned DEB_W     = 20,
   parameter logic [15:0] INIT_VAL  = 16'hABCD
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DIGITS-1:0]   btn,
   input  logic                clr,
   output logic [15:0]         num,
   output logic                upd_valid,
   output logic [1:0]          upd_idx,
   output logic                busy
);

   logic [DIGITS-1:0] rise;
   logic [DIGITS-1:0] pending;
   logic [DIGITS-1:0] pending_nxt;
   logic [DIGITS-1:0] grant_mask;
   logic [1:0]        rr_ptr;
   logic [1:0]        grant_q;
   logic [1:0]        pick;
   logic              pick_vld;
   logic              grant_ld;
   logic              do_write;
   logic [15:0]       num_inc;
   state_t            state;
   state_t            state_nxt;

   for (genvar i = 0; i < DIGITS; i++) begin : g_deb
      btn_debounce #(
         .DEB_LIMIT (DEB_LIMIT),
         .DEB_W     (DEB_W)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .btn   (btn[i]),
         .rise  (rise[i])
      );
   end

   // Round-robin pick: first pending digit at or after rr_ptr, wrapping mod 4.
   always_comb begin
      pick     = rr_ptr;
      pick_vld = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (!pick_vld && pending[rr_ptr + 2'(k)]) begin
            pick     = rr_ptr + 2'(k);
            pick_vld = 1'b1;
         end
      end
   end

   // FSM next state and per-cycle controls; clr overrides everything.
   always_comb begin
      state_nxt = state;
      grant_ld  = 1'b0;
      do_write  = 1'b0;
      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               grant_ld  = 1'b1;
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            do_write  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (clr) begin
         grant_ld  = 1'b0;
         do_write  = 1'b0;
         state_nxt = S_IDLE;
      end
   end

   // A new press on the digit being granted in the same cycle must survive, so set is OR-ed last.
   always_comb begin
      grant_mask  = grant_ld ? (4'b0001 << pick) : 4'b0000;
      pending_nxt = (pending & ~grant_mask) | rise;
      if (clr) begin
         pending_nxt = '0;
      end
   end

   // Shared incrementer: only the granted nibble changes, wrapping F->0 with no carry out.
   always_comb begin
      num_inc = num;
      num_inc[digit_lsb(grant_q) +: DIGIT_W] = num[digit_lsb(grant_q) +: DIGIT_W] + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         rr_ptr    <= 2'd0;
         grant_q   <= 2'd0;
         num       <= INIT_VAL;
         upd_valid <= 1'b0;
         upd_idx   <= 2'd0;
      end else begin
         pending   <= pending_nxt;
         upd_valid <= do_write;
         if (grant_ld) begin
            grant_q <= pick;
         end
         if (clr) begin
            num <= INIT_VAL;
         end else if (do_write) begin
            num     <= num_inc;
            upd_idx <= grant_q;
            rr_ptr  <= grant_q + 2'd1;
         end
      end
   end

   assign busy = (|pending) || (state != S_IDLE);

endmodule
